led_fader: RTL
==============

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 The block SHALL expose parameter PWM_BITS, default 8, meaning width of the brightness level and PWM counter.
REQ-002 The block SHALL expose parameter STEP, default 32, meaning brightness change per tick (1..2^PWM_BITS-1).
REQ-003 clk  input  1  sole clock, all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 led_in  input  1  target level from the upstream blinker (1 = on, 0 = off).
REQ-006 tick  input  1  single-cycle step pulse, the blinker's wrap flag.
REQ-007 pwm_out  output  1  registered PWM drive to the LED pin.
REQ-008 level  output  PWM_BITS  current brightness, registered.
REQ-009 busy  output  1  high while ramping.
REQ-010 at_target  output  1  high when level equals the led_in target, i.e. in state ON with led_in=1 or state OFF with led_in=0.

Function
REQ-011 The FSM SHALL have exactly the states OFF, RAMP_UP, ON and RAMP_DOWN.
REQ-012 Transitions: OFF&led_in=1 -> RAMP_UP; ON&led_in=0 -> RAMP_DOWN; RAMP_UP&led_in=0 -> RAMP_DOWN; RAMP_DOWN&led_in=1 -> RAMP_UP; all take effect the next cycle without needing tick.
REQ-013 level SHALL change only in a cycle with tick=1 and no direction change that cycle; a reversal in the tick cycle takes precedence and level holds.
REQ-014 RAMP_UP with tick: level <= min(level+STEP, 2^PWM_BITS-1), computed PWM_BITS+1 wide; on reaching max, state -> ON in the same update.
REQ-015 RAMP_DOWN with tick: level <= max(level-STEP, 0), no underflow wrap; on reaching 0, state -> OFF in the same update.
REQ-016 tick in OFF or ON SHALL be ignored; tick held high continuously SHALL step once per cycle.
REQ-017 The PWM counter SHALL be free-running, PWM_BITS wide, incrementing every cycle and wrapping max -> 0.
REQ-018 pwm_out SHALL be registered: next = 1 in ON, 0 in OFF, else (pwm_cnt < level); one-cycle latency.
REQ-019 busy SHALL equal (state==RAMP_UP || state==RAMP_DOWN), combinational from state.
REQ-020 With led_in held constant and tick asserted infinitely often, at_target SHALL eventually hold forever.

Reset
REQ-021 While rst_n=0 at posedge clk, the block SHALL load state=OFF, level=0, pwm_cnt=0 and pwm_out=0, overriding led_in and tick.
REQ-022 Reset asserted mid-ramp SHALL abort the ramp with no residual level; operation resumes from OFF the first cycle after rst_n=1.

Structure
REQ-023 Package led_fader_pkg SHALL hold the 2-bit enum fade_state_t {OFF, RAMP_UP, ON, RAMP_DOWN} and constants DEF_PWM_BITS=8 and DEF_STEP=32.
REQ-024 The PWM counter and comparator SHALL be a sub-module pwm_gen (params PWM_BITS; ports clk, rst_n, level, force_on, force_off, pwm_out); the FSM and level arithmetic SHALL stay in led_fader.

Verification (PWM_BITS=8, STEP=64)
REQ-025 Reset: rst_n=0 for 2 cycles with led_in=1 and tick=1 -> state OFF, level 0, pwm_out 0, busy 0.
REQ-026 Ramp up: led_in 0->1, then 4 ticks -> level 64, 128, 192, 255 (saturated); state ON and busy 0 after the 4th tick; pwm_out 1 one cycle later.
REQ-027 Reversal: at level 128 in RAMP_UP, led_in=0 coincident with tick -> state RAMP_DOWN, level stays 128; next tick -> 64.
REQ-028 Duty: level held at 64 with no tick for 256 consecutive cycles -> pwm_out high in exactly 64 of them.
REQ-029 Mid-ramp reset: at level 192 in RAMP_UP, rst_n=0 for 1 cycle -> level 0, state OFF, pwm_out 0 on the next cycle.
REQ-030 Formal: a property SHALL prove that if eventually rst_n=1 and led_in=1 hold forever with tick infinitely often, then eventually at_target=1 and pwm_out=1 hold forever.

Source files
------------

// File: rtl/led_fader_pkg.sv
// -----------------------------------------------------------------------------
// led_fader_pkg
//   Shared types and defaults for the LED fader.
//   fade_state_t : 2-bit fader state {OFF, RAMP_UP, ON, RAMP_DOWN}
//   DEF_PWM_BITS : default brightness / PWM counter width
//   DEF_STEP     : default brightness change per tick
// -----------------------------------------------------------------------------
package led_fader_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } fade_state_t;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_STEP     = 32;

endpackage

// File: rtl/led_fader_pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
//   Free-running PWM counter and registered comparator.
//   clk       : clock, all updates on posedge
//   rst_n     : synchronous active-low reset (counter and output cleared)
//   level     : duty level, output high while counter < level
//   force_on  : drive output constantly high (takes priority)
//   force_off : drive output constantly low
//   pwm_out   : registered PWM output, one cycle behind its inputs
// -----------------------------------------------------------------------------
module pwm_gen
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] level,
    input  logic                force_on,
    input  logic                force_off,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] pwm_cnt_p0;
    logic                pwm_nxt;

    always_comb begin
        pwm_nxt = 1'b0;
        if (force_on) begin
            pwm_nxt = 1'b1;
        end else if (force_off) begin
            pwm_nxt = 1'b0;
        end else begin
            pwm_nxt = (pwm_cnt_p0 < level);
        end
    end

    // Stage p0 -> output register: counter wraps naturally at its width
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_p0 <= '0;
            pwm_out    <= 1'b0;
        end else begin
            pwm_cnt_p0 <= pwm_cnt_p0 + 1'b1;
            pwm_out    <= pwm_nxt;
        end
    end

endmodule

// File: rtl/led_fader.sv
// -----------------------------------------------------------------------------
// led_fader
//   Smoothly ramps LED brightness toward the on/off target from a blinker.
//   clk       : clock, all updates on posedge
//   rst_n     : synchronous active-low reset
//   led_in    : target (1 = on, 0 = off)
//   tick      : step pulse; each tick while ramping moves level by STEP
//   pwm_out   : registered PWM drive for the LED pin
//   level     : current brightness (registered)
//   busy      : high while ramping up or down
//   at_target : high when fully ON with led_in=1 or fully OFF with led_in=0
// -----------------------------------------------------------------------------
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS,
    parameter int STEP     = DEF_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                led_in,
    input  logic                tick,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] level,
    output logic                busy,
    output logic                at_target
);

    localparam logic [PWM_BITS:0]   STEP_W  = STEP[PWM_BITS:0];
    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

    // Add with one guard bit; a carry means we passed full scale.
    function automatic logic [PWM_BITS-1:0] sat_add(input logic [PWM_BITS-1:0] l);
        logic [PWM_BITS:0] sum;
        sum = {1'b0, l} + STEP_W;
        if (sum[PWM_BITS]) begin
            sat_add = LVL_MAX;
        end else begin
            sat_add = sum[PWM_BITS-1:0];
        end
    endfunction

    // Signed subtract so a step past zero clamps instead of wrapping.
    function automatic logic [PWM_BITS-1:0] sat_sub(input logic [PWM_BITS-1:0] l);
        logic signed [PWM_BITS+1:0] diff;
        diff = $signed({2'b00, l}) - $signed({1'b0, STEP_W});
        if (diff < 0) begin
            sat_sub = '0;
        end else begin
            sat_sub = diff[PWM_BITS-1:0];
        end
    endfunction

    fade_state_t         state_p0, state_nxt;
    logic [PWM_BITS-1:0] level_p0, level_nxt;
    logic [PWM_BITS-1:0] lvl_up, lvl_dn;

    assign lvl_up = sat_add(level_p0);
    assign lvl_dn = sat_sub(level_p0);

    // A direction change always wins over a coincident tick; level holds.
    always_comb begin
        state_nxt = state_p0;
        level_nxt = level_p0;
        case (state_p0)
            OFF: begin
                if (led_in) state_nxt = RAMP_UP;
            end
            ON: begin
                if (!led_in) state_nxt = RAMP_DOWN;
            end
            RAMP_UP: begin
                if (!led_in) begin
                    state_nxt = RAMP_DOWN;
                end else if (tick) begin
                    level_nxt = lvl_up;
                    if (lvl_up == LVL_MAX) state_nxt = ON;
                end
            end
            RAMP_DOWN: begin
                if (led_in) begin
                    state_nxt = RAMP_UP;
                end else if (tick) begin
                    level_nxt = lvl_dn;
                    if (lvl_dn == '0) state_nxt = OFF;
                end
            end
            default: begin
                state_nxt = OFF;
                level_nxt = '0;
            end
        endcase
    end

    // Stage p0: state and brightness registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= OFF;
            level_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            level_p0 <= level_nxt;
        end
    end

    assign level     = level_p0;
    assign busy      = (state_p0 == RAMP_UP) || (state_p0 == RAMP_DOWN);
    assign at_target = ((state_p0 == ON) && led_in) || ((state_p0 == OFF) && !led_in);

    logic force_on, force_off;
    assign force_on  = (state_p0 == ON);
    assign force_off = (state_p0 == OFF);

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .level     (level_p0),
        .force_on  (force_on),
        .force_off (force_off),
        .pwm_out   (pwm_out)
    );

`ifdef FORMAL
    // Fair ticks plus a steady on-request must end fully lit, and stay there.
    assume property (@(posedge clk) s_eventually tick);
    assert property (@(posedge clk) disable iff (!rst_n || !led_in)
        s_eventually (at_target && pwm_out));
    assert property (@(posedge clk) disable iff (!rst_n || !led_in)
        (at_target && pwm_out) |=> (at_target && pwm_out));
`endif

endmodule
